// File: rtl/div_arbiter_ctl.sv
// Round-robin controller sharing one fixed-point divider between two requesters.
// Sequences clear, start and completion wait, then returns a tagged response.
module div_arbiter_ctl #(
    parameter int W       = 10,
    parameter int CLR_CYC = 2,
    parameter int TIMEOUT = 128
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [1:0]     req_valid,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    output logic [1:0]     req_ack,
    output logic           rsp_valid,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_q,
    output logic           rsp_dvz,
    output logic           rsp_ovf,
    output logic           rsp_tmo,
    output logic           ctl_busy,
    output logic [W-1:0]   div_a,
    output logic [W-1:0]   div_b,
    output logic           div_reset,
    output logic           div_start,
    input  logic [W-1:0]   div_q,
    input  logic           div_busy,
    input  logic           div_dvz,
    input  logic           div_ovf,
    input  logic           div_valid
);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_START, S_WAIT, S_RESP} state_e;

    localparam int CMAX = (CLR_CYC > TIMEOUT) ? CLR_CYC : TIMEOUT;
    localparam int CW   = $clog2(CMAX);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           last_id_q, last_id_d;
    logic           cur_id_q, cur_id_d;
    logic [1:0]     req_ack_q, req_ack_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_q_q, rsp_q_d;
    logic           rsp_dvz_q, rsp_dvz_d;
    logic           rsp_ovf_q, rsp_ovf_d;
    logic           rsp_tmo_q, rsp_tmo_d;
    logic           busy_q, busy_d;
    logic [W-1:0]   div_a_q, div_a_d;
    logic [W-1:0]   div_b_q, div_b_d;
    logic           div_reset_q, div_reset_d;
    logic           div_start_q, div_start_d;

    logic           gnt_id;
    logic           done;

    // On a tie the requester not served last wins.
    assign gnt_id = (req_valid == 2'b11) ? ~last_id_q : req_valid[1];
    assign done   = ~div_busy & (div_valid | div_dvz | div_ovf);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_id_d   = last_id_q;
        cur_id_d    = cur_id_q;
        req_ack_d   = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_q_d     = rsp_q_q;
        rsp_dvz_d   = rsp_dvz_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_tmo_d   = rsp_tmo_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        div_reset_d = 1'b0;
        div_start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    state_d     = S_CLR;
                    req_ack_d   = gnt_id ? 2'b10 : 2'b01;
                    div_a_d     = gnt_id ? req_a[2*W-1:W] : req_a[W-1:0];
                    div_b_d     = gnt_id ? req_b[2*W-1:W] : req_b[W-1:0];
                    cur_id_d    = gnt_id;
                    last_id_d   = gnt_id;
                    cnt_d       = '0;
                    div_reset_d = 1'b1;
                end
            end
            S_CLR: begin
                if (cnt_q == CW'(CLR_CYC - 1)) begin
                    state_d     = S_START;
                    cnt_d       = '0;
                    div_start_d = 1'b1;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    div_reset_d = 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // Completion is checked first so it wins over a same-cycle timeout.
                if (done) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    rsp_q_d     = div_q;
                    rsp_dvz_d   = div_dvz;
                    rsp_ovf_d   = div_ovf;
                    rsp_tmo_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    rsp_q_d     = '0;
                    rsp_dvz_d   = 1'b0;
                    rsp_ovf_d   = 1'b0;
                    rsp_tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_id_q   <= 1'b1;
            cur_id_q    <= 1'b0;
            req_ack_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_q_q     <= '0;
            rsp_dvz_q   <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            busy_q      <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            div_reset_q <= 1'b0;
            div_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_id_q   <= last_id_d;
            cur_id_q    <= cur_id_d;
            req_ack_q   <= req_ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q_q     <= rsp_q_d;
            rsp_dvz_q   <= rsp_dvz_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_tmo_q   <= rsp_tmo_d;
            busy_q      <= busy_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            div_reset_q <= div_reset_d;
            div_start_q <= div_start_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_dvz   = rsp_dvz_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_tmo   = rsp_tmo_q;
    assign ctl_busy  = busy_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign div_reset = div_reset_q;
    assign div_start = div_start_q;

endmodule

// File: tb/tb_div_arbiter_ctl.sv
// Bench for div_arbiter_ctl: directed and randomized operations against a
// behavioural divider and an arbitration/timing reference model.
module tb_div_arbiter_ctl;

    localparam int W       = 10;
    localparam int CLR_CYC = 2;
    localparam int TIMEOUT = 128;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [1:0]     req_valid = '0;
    logic [2*W-1:0] req_a = '0;
    logic [2*W-1:0] req_b = '0;
    logic [1:0]     req_ack;
    logic           rsp_valid, rsp_id, rsp_dvz, rsp_ovf, rsp_tmo, ctl_busy;
    logic [W-1:0]   rsp_q, div_a, div_b, div_q;
    logic           div_reset, div_start;
    logic           div_busy, div_dvz, div_ovf, div_valid;

    div_arbiter_ctl #(.W(W), .CLR_CYC(CLR_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ack(req_ack),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q),
        .rsp_dvz(rsp_dvz), .rsp_ovf(rsp_ovf), .rsp_tmo(rsp_tmo), .ctl_busy(ctl_busy),
        .div_a(div_a), .div_b(div_b), .div_reset(div_reset), .div_start(div_start),
        .div_q(div_q), .div_busy(div_busy), .div_dvz(div_dvz), .div_ovf(div_ovf),
        .div_valid(div_valid)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_cnt0 = 0;
    int ack_cnt1 = 0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (req_ack[0]) ack_cnt0 <= ack_cnt0 + 1;
        if (req_ack[1]) ack_cnt1 <= ack_cnt1 + 1;
    end

    // Divider model: Q = (A<<4)/B, answers m_dly cycles after start unless hung.
    int           m_dly = 1;
    bit           m_hang = 1'b0;
    logic         m_active = 1'b0;
    int           m_k = 0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic         done_m;

    always @(negedge clock) begin
        if (!reset || div_reset) m_active <= 1'b0;
        else if (div_start) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_a      <= div_a;
            m_b      <= div_b;
        end else if (m_active) m_k <= m_k + 1;
    end

    always_comb begin
        done_m    = m_active && !m_hang && (m_k >= m_dly);
        div_busy  = m_active && !done_m;
        div_valid = 1'b0;
        div_dvz   = 1'b0;
        div_ovf   = 1'b0;
        div_q     = '0;
        if (done_m) begin
            if (m_b == '0) div_dvz = 1'b1;
            else if ((int'(m_a) * 16) / int'(m_b) > 1023) begin
                div_ovf = 1'b1;
                div_q   = '1;
            end else begin
                div_valid = 1'b1;
                div_q     = W'((int'(m_a) * 16) / int'(m_b));
            end
        end
    end

    // Reference state: requester served most recently.
    int m_last = 1;
    int last_ack_cyc = 0;
    int last_rsp_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        if (i == 0) begin
            req_a[W-1:0] = a;
            req_b[W-1:0] = b;
        end else begin
            req_a[2*W-1:W] = a;
            req_b[2*W-1:W] = b;
        end
        req_valid[i] = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_b();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return '0;
        if (r == 1) return W'(1);
        return W'($urandom_range(1, 1023));
    endfunction

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        m_last    = 1;
        repeat (2) @(negedge clock);
        chk("reset_rsp", {req_ack, rsp_valid, rsp_id, rsp_q, rsp_dvz, rsp_ovf, rsp_tmo, ctl_busy}, '0);
        chk("reset_div", {div_a, div_b, div_reset, div_start}, '0);
        reset = 1'b1;
    endtask

    // One full operation: expected winner and result come from the reference model.
    task automatic serve(input bit keep, output int id);
        int e, n, t, rcnt, scnt, ack_c;
        logic [W-1:0] ea, eb, eq;
        logic edvz, eovf, etmo;
        if (req_valid == 2'b11) e = (m_last == 1) ? 0 : 1;
        else e = req_valid[1] ? 1 : 0;
        ea = (e == 1) ? req_a[2*W-1:W] : req_a[W-1:0];
        eb = (e == 1) ? req_b[2*W-1:W] : req_b[W-1:0];
        edvz = 1'b0; eovf = 1'b0; etmo = 1'b0; eq = '0;
        if (m_hang) begin
            etmo = 1'b1;
            n    = TIMEOUT;
        end else begin
            n = m_dly;
            if (eb == '0) edvz = 1'b1;
            else if ((int'(ea) * 16) / int'(eb) > 1023) begin
                eovf = 1'b1;
                eq   = '1;
            end else eq = W'((int'(ea) * 16) / int'(eb));
        end

        t = 0;
        while (req_ack == 2'b00 && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("ack_onehot", req_ack, (e == 1) ? 2'b10 : 2'b01);
        chk("div_a", div_a, ea);
        chk("div_b", div_b, eb);
        chk("busy_op", ctl_busy, 1);
        ack_c  = cyc;
        m_last = e;
        id     = e;
        if (keep) set_req(e, W'($urandom_range(0, 1023)), rnd_b());
        else req_valid[e] = 1'b0;

        rcnt = int'(div_reset);
        scnt = 0;
        t    = 0;
        do begin
            @(negedge clock);
            t++;
            if (t == 1) chk("ack_pulse", req_ack, 0);
            chk("rst_start_excl", div_reset & div_start, 0);
            rcnt += int'(div_reset);
            scnt += int'(div_start);
        end while (!rsp_valid && t < CLR_CYC + TIMEOUT + 20);
        chk("rsp_valid", rsp_valid, 1);
        chk("latency", cyc - (ack_c - 1), CLR_CYC + 1 + n + 1);
        chk("rsp_id", rsp_id, e);
        chk("rsp_q", rsp_q, eq);
        chk("rsp_flags", {rsp_dvz, rsp_ovf, rsp_tmo}, {edvz, eovf, etmo});
        chk("clr_cycles", rcnt, CLR_CYC);
        chk("start_cycles", scnt, 1);
        last_ack_cyc = ack_c;
        last_rsp_cyc = cyc;
        @(negedge clock);
        chk("rsp_pulse", rsp_valid, 0);
        chk("idle_busy", ctl_busy, 0);
        chk("rsp_hold", rsp_q, eq);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int id, a0, a1, rsp0, t;

        // Reset state
        @(negedge clock);
        do_reset();

        // Single request
        m_dly = 60;
        set_req(0, W'(10'h060), W'(10'h010));
        serve(1'b0, id);
        chk("single_id", id, 0);
        chk("single_q", rsp_q, 10'h060);

        // Tie after reset: req0 first, req1 after one idle cycle
        do_reset();
        m_dly = $urandom_range(1, 12);
        a0 = ack_cnt0;
        a1 = ack_cnt1;
        set_req(0, W'(10'h060), W'(10'h010));
        set_req(1, W'(10'h320), W'(10'h320));
        serve(1'b0, id);
        chk("tie_first", id, 0);
        rsp0 = last_rsp_cyc;
        serve(1'b0, id);
        chk("tie_second", id, 1);
        chk("tie_q1", rsp_q, 10'h010);
        chk("tie_gap", last_ack_cyc - rsp0, 2);
        chk("tie_acks0", ack_cnt0 - a0, 1);
        chk("tie_acks1", ack_cnt1 - a1, 1);

        // Round-robin with both requesters continuously valid
        set_req(0, W'($urandom_range(0, 1023)), rnd_b());
        set_req(1, W'($urandom_range(0, 1023)), rnd_b());
        for (int k = 0; k < 4; k++) begin
            m_dly = $urandom_range(1, 12);
            serve(1'b1, id);
            chk("rr_order", id, k % 2);
        end
        req_valid = '0;
        @(negedge clock);

        // Divide by zero
        m_dly = 3;
        set_req(0, W'(10'h100), W'(10'h000));
        serve(1'b0, id);
        chk("dvz_flags", {rsp_dvz, rsp_ovf, rsp_tmo}, 3'b100);

        // Timeout, then a normal operation
        m_hang = 1'b1;
        set_req(0, W'($urandom_range(0, 1023)), W'($urandom_range(1, 1023)));
        serve(1'b0, id);
        chk("tmo_flag", rsp_tmo, 1);
        chk("tmo_q", rsp_q, 0);
        m_hang = 1'b0;
        m_dly  = 5;
        set_req(1, W'(10'h0F0), W'(10'h030));
        serve(1'b0, id);
        chk("post_tmo_q", rsp_q, 10'h050);

        // Reset during WAIT aborts; waiting req1 served afterwards
        m_dly = 40;
        set_req(0, W'(10'h123), W'(10'h045));
        t = 0;
        while (req_ack == 2'b00 && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("abort_ack", req_ack, 2'b01);
        req_valid[0] = 1'b0;
        set_req(1, W'(10'h200), W'(10'h040));
        t = 0;
        while (!div_start && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("abort_start", div_start, 1);
        repeat (10) @(negedge clock);
        reset  = 1'b0;
        m_last = 1;
        #1;
        chk("abort_rsp_zero", {req_ack, rsp_valid, rsp_id, rsp_q, rsp_dvz, rsp_ovf, rsp_tmo, ctl_busy}, '0);
        chk("abort_div_zero", {div_a, div_b, div_reset, div_start}, '0);
        repeat (2) begin
            @(negedge clock);
            chk("abort_no_rsp", rsp_valid, 0);
        end
        reset = 1'b1;
        m_dly = 4;
        serve(1'b0, id);
        chk("abort_next_id", id, 1);
        chk("abort_next_q", rsp_q, 10'h080);

        // Randomized traffic
        for (int it = 0; it < 16; it++) begin
            for (int r = 0; r < 2; r++)
                if (!req_valid[r] && ($urandom_range(0, 1) == 1))
                    set_req(r, W'($urandom_range(0, 1023)), rnd_b());
            if (req_valid == 2'b00) set_req(0, W'($urandom_range(0, 1023)), rnd_b());
            m_dly = $urandom_range(1, 12);
            serve(1'b0, id);
        end
        while (req_valid != 2'b00) begin
            m_dly = $urandom_range(1, 12);
            serve(1'b0, id);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_arbiter_ctl.md
Name: div_arbiter_ctl

Overview:
Controller that shares one fixed-point divider (10-bit operands A/B, result Q, status busy/dvz/ovf/valid) between two requesters. It arbitrates round-robin and latches the winner's operands. It then sequences the divider through a clear pulse, a one-cycle start pulse and a wait for completion, and returns the quotient and status to the winner on a shared response bus tagged with requester id. A watchdog reports a timeout if the divider never completes.

Parameters:
W, 10, operand/quotient width
CLR_CYC, 2, cycles div_reset is held high before each operation (>=1)
TIMEOUT, 128, max WAIT cycles before timeout (>=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  2  per-requester request; operands held stable until matching req_ack
req_a  in  2*W  dividends, requester i at [i*W +: W]
req_b  in  2*W  divisors, same packing
req_ack  out  2  one-cycle pulse: operands of requester i latched
rsp_valid  out  1  one-cycle pulse: response fields valid
rsp_id  out  1  requester the response belongs to
rsp_q  out  W  quotient captured from divider
rsp_dvz  out  1  divide-by-zero flag
rsp_ovf  out  1  overflow flag
rsp_tmo  out  1  watchdog timeout flag
ctl_busy  out  1  high in any state except IDLE
div_a, div_b  out  W  registered operands to divider
div_reset  out  1  active-high clear to divider
div_start  out  1  start pulse to divider
div_q  in  W  divider quotient
div_busy, div_dvz, div_ovf, div_valid  in  1  divider status

Behaviour:
- One clock; reset is asynchronous and active-low.
- While reset is low: state=IDLE, all outputs 0, last_id=1 (requester 0 wins first tie), counters 0.
- All outputs are registered.
- IDLE: grant on req_valid; if both requesters are valid, grant !last_id. On grant:
  - latch req_a/req_b slice into div_a/div_b;
  - pulse req_ack[id] for one cycle;
  - set cur_id=id and last_id=id;
  - go to CLR.
- IDLE with no request: stay in IDLE.
- CLR: div_reset=1 for exactly CLR_CYC cycles, then go to START.
- START: div_start=1 for exactly one cycle, then go to WAIT. The WAIT counter is cleared.
- WAIT: counter increments each cycle.
  - Completion condition: div_busy=0 AND (div_valid | div_dvz | div_ovf).
  - On completion: capture div_q, div_dvz, div_ovf into rsp_*; rsp_tmo=0; go to RESP.
  - If the counter reaches TIMEOUT-1 without completion: rsp_q=0, rsp_dvz=0, rsp_ovf=0, rsp_tmo=1; go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP: rsp_valid=1 and rsp_id=cur_id for one cycle, then go to IDLE.
- Response fields hold their values until the next RESP.
- div_a/div_b stay stable from grant until the next grant.
- Latency from grant cycle to rsp_valid = CLR_CYC + 1 + N_wait + 1 cycles. N_wait is the number of WAIT cycles (>=1).
- At most one idle cycle separates back-to-back operations.
- A requester that drops req_valid before its ack is withdrawn and not served. req_valid is ignored outside IDLE.
- A new request from the just-served requester while the other is waiting loses the tie (fairness).
- Reset mid-operation aborts immediately: no response is issued, and the divider is cleared on the next operation's CLR. An acked-but-unanswered request is lost; re-issuing it is the requester's responsibility.
- div_reset and div_start are never high in the same cycle.

Test Plan:
- Single request: req0 with A=0x060, B=0x010; divider model answers Q=0x060 after 60 cycles -> req_ack[0] in grant cycle, then div_reset high 2 cycles, div_start high 1 cycle, rsp_valid with rsp_id=0, rsp_q=0x060 and all flags 0, exactly 2+1+60+1 cycles after grant.
- Tie after reset: both requesters valid in the same cycle (req1 A=0x320, B=0x320) -> req0 served first, then req1 served after one idle cycle. rsp_id sequence is 0 then 1, and each requester gets exactly one ack.
- Round-robin: req0 held continuously valid and re-requesting, req1 valid -> grants alternate 0,1,0,1 over 4 operations.
- Divide by zero: A=0x100, B=0x000; model raises dvz with busy=0 after 3 cycles -> rsp_dvz=1, rsp_ovf=0, rsp_tmo=0.
- Timeout: model holds div_busy=1 forever, TIMEOUT=128 -> rsp_tmo=1 and rsp_q=0 exactly 128 WAIT cycles after START; controller returns to IDLE and serves the next request normally.
- Reset mid-WAIT: reset pulled low for 2 cycles at WAIT cycle 10 -> outputs 0 immediately and no rsp_valid. After release, the still-valid req1 is granted (last_id=1 restored, so req0 wins any tie).
